// File: rtl/qc_ldpc_pkg.sv
// Shared QC-LDPC definitions: default lifting size, the 802.11n Z list,
// and the bit-level golden cyclic-rotate model.
package qc_ldpc_pkg;

    localparam int MAXZ_DEFAULT    = 81;
    localparam int SHIFT_W_DEFAULT = $clog2(MAXZ_DEFAULT);
    localparam int NUM_Z           = 3;
    localparam int Z_LIST [NUM_Z]  = '{27, 54, 81};

    typedef logic [SHIFT_W_DEFAULT:0]   z_t;
    typedef logic [SHIFT_W_DEFAULT-1:0] zidx_t;
    typedef logic [MAXZ_DEFAULT-1:0]    zword_t;

    // out[i] = data[(i + s) mod z] for i < z, zero above z.
    function automatic zword_t rot_right_z(zword_t data, int z, int s);
        zword_t r;
        zidx_t  src;
        zidx_t  dst;
        r = '0;
        for (int i = 0; i < MAXZ_DEFAULT; i++) begin
            if (i < z) begin
                src    = zidx_t'((i + s) % z);
                dst    = zidx_t'(i);
                r[dst] = data[src];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qc_zrot_stage.sv
// Combinational rotate-right by 2^K within the low z bits of a MAXZ-wide word.
// Assumes bits at and above z are already zero on entry.
module qc_zrot_stage #(
    parameter int MAXZ = 81,
    parameter int K    = 0
) (
    input  logic [MAXZ-1:0]       x,
    input  logic [$clog2(MAXZ):0] z,
    input  logic                  en,
    output logic [MAXZ-1:0]       y
);

    localparam int            ZW  = $clog2(MAXZ) + 1;
    localparam logic [ZW-1:0] AMT = ZW'(2 ** K);

    logic [MAXZ-1:0] zmask;
    logic [ZW-1:0]   wrap;

    assign zmask = ~({MAXZ{1'b1}} << z);
    assign wrap  = z - AMT;

    // Low bits wrap around to position z-2^K; a step of 2^K >= z never has its bit set.
    assign y = (en && (AMT < z)) ? (((x >> AMT) | (x << wrap)) & zmask) : x;

endmodule

// File: rtl/qc_var_z_cyclic_shifter.sv
// Pipelined variable-Z cyclic shifter for QC-LDPC with valid/ready handshake,
// rotate direction select, illegal-beat flagging and a tag sideband.
module qc_var_z_cyclic_shifter
    import qc_ldpc_pkg::*;
#(
    parameter int MAXZ             = MAXZ_DEFAULT,
    parameter int SHIFT_W          = $clog2(MAXZ),
    parameter int STAGES_PER_CYCLE = 1,
    parameter int TAG_W            = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAXZ-1:0]    in_data,
    input  logic [SHIFT_W:0]   z_size,
    input  logic [SHIFT_W-1:0] shift_val,
    input  logic               dir,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAXZ-1:0]    out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    localparam int ZW    = SHIFT_W + 1;
    localparam int RANKS = (SHIFT_W + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;

    // Rank 0 is the input register; rank RANKS drives the outputs.
    logic               rk_valid [RANKS+1];
    logic [MAXZ-1:0]    rk_data  [RANKS+1];
    logic [ZW-1:0]      rk_z     [RANKS+1];
    logic [SHIFT_W-1:0] rk_shift [RANKS+1];
    logic               rk_err   [RANKS+1];
    logic [TAG_W-1:0]   rk_tag   [RANKS+1];
    logic [MAXZ-1:0]    rank_in_data [RANKS+1];

    logic               stall;
    logic               in_err;
    logic [MAXZ-1:0]    in_mask;
    logic [SHIFT_W-1:0] in_shift;

    assign stall    = rk_valid[RANKS] & ~out_ready;
    assign in_ready = ~stall;

    assign in_err  = (z_size == '0) || (z_size > ZW'(MAXZ)) || (ZW'(shift_val) >= z_size);
    assign in_mask = ~({MAXZ{1'b1}} << z_size);

    // Left by s is right by (z - s) mod z; illegal beats carry no rotation.
    always_comb begin
        // NOTE: assign a default first so no path leaves in_shift unassigned and infers a latch.
        in_shift = '0;
        if (!in_err)
            in_shift = (dir && shift_val != '0) ? SHIFT_W'(z_size - ZW'(shift_val)) : shift_val;
    end

    assign rank_in_data[0] = in_err ? '0 : (in_data & in_mask);

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        localparam int R = k / STAGES_PER_CYCLE;
        logic [MAXZ-1:0] stage_in;
        logic [MAXZ-1:0] y;

        if (k % STAGES_PER_CYCLE == 0) begin : g_head
            assign stage_in = rk_data[R];
        end else begin : g_chain
            assign stage_in = g_stage[k-1].y;
        end

        qc_zrot_stage #(.MAXZ(MAXZ), .K(k)) u_rot (
            .x  (stage_in),
            .z  (rk_z[R]),
            .en (rk_shift[R][k]),
            .y  (y)
        );
    end

    for (genvar r = 1; r <= RANKS; r++) begin : g_rank
        localparam int LAST =
            ((r * STAGES_PER_CYCLE < SHIFT_W) ? r * STAGES_PER_CYCLE : SHIFT_W) - 1;
        assign rank_in_data[r] = g_stage[LAST].y;
    end

    // The whole shift value rides along; each stage picks its own bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are pipeline registers, not a RAM, so every rank is reset to flush in-flight beats.
            for (int r = 0; r <= RANKS; r++) begin
                rk_valid[r] <= 1'b0;
                rk_data[r]  <= '0;
                rk_z[r]     <= '0;
                rk_shift[r] <= '0;
                rk_err[r]   <= 1'b0;
                rk_tag[r]   <= '0;
            end
        end else if (!stall) begin
            // NOTE: non-blocking so every rank samples its predecessor's pre-edge value.
            rk_valid[0] <= in_valid;
            rk_data[0]  <= rank_in_data[0];
            rk_z[0]     <= z_size;
            rk_shift[0] <= in_shift;
            rk_err[0]   <= in_err;
            rk_tag[0]   <= in_tag;
            for (int r = 1; r <= RANKS; r++) begin
                rk_valid[r] <= rk_valid[r-1];
                rk_data[r]  <= rank_in_data[r];
                rk_z[r]     <= rk_z[r-1];
                rk_shift[r] <= rk_shift[r-1];
                rk_err[r]   <= rk_err[r-1];
                rk_tag[r]   <= rk_tag[r-1];
            end
        end
    end

    assign out_valid = rk_valid[RANKS];
    assign out_data  = rk_valid[RANKS] ? rk_data[RANKS] : '0;
    assign out_err   = rk_valid[RANKS] & rk_err[RANKS];
    assign out_tag   = rk_tag[RANKS];

endmodule
